clkdiv_cfg_ctrl: RTL
====================

CLKDIV_CFG_CTRL -- requirements
Module: clkdiv_cfg_ctrl

Interface
REQ-001 The block SHALL have one clock, I_ref_clk; reset is asynchronous and active-low (I_rst_n).
REQ-002 The block SHALL have parameters (name, default, meaning):
- DRAIN_CYC, 4, cycles the divider is held disabled before a ratio change; legal range 1..255.
- SETTLE_CYC, 2, cycles held disabled after a ratio change; legal range 1..255.
- RESET_RATIO, 8'd2, divide ratio driven out of reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- I_ref_clk, in, 1, reference clock shared with the divider.
- I_rst_n, in, 1, asynchronous active-low reset.
- I_enable, in, 1, system request for the divided clock to run.
- I_req_vld, in, 1, new-ratio request valid.
- I_req_ratio, in, 8, requested divide ratio.
- o_req_rdy, out, 1, controller can accept a request.
- o_div_ratio, out, 8, ratio driven to the divider I_div_ratio.
- o_clk_en, out, 1, enable driven to the divider I_clk_en.
- o_busy, out, 1, ratio-change sequence in progress.
- o_cfg_err, out, 1, one-cycle pulse when an illegal ratio is rejected (see Configuration).

Function
REQ-004 The FSM SHALL have four states, with IDLE as the reset state:
- IDLE -> DRAIN on an accepted request whose ratio differs from o_div_ratio.
- DRAIN -> LOAD after exactly DRAIN_CYC cycles.
- LOAD -> SETTLE after 1 cycle.
- SETTLE -> IDLE after exactly SETTLE_CYC cycles.
REQ-005 o_req_rdy SHALL be 1 only in IDLE; it is decoded from the state register.
REQ-006 A request SHALL be accepted on a rising edge where I_req_vld=1 and o_req_rdy=1; I_req_ratio is captured on that edge.
REQ-007 An accepted request equal to the current o_div_ratio SHALL complete the handshake, stay in IDLE and leave o_clk_en and o_div_ratio unchanged.
REQ-008 On the acceptance edge that enters DRAIN, o_clk_en SHALL go to 0 and o_busy to 1 (both registered).
REQ-009 o_div_ratio SHALL take the captured ratio on the edge entering LOAD, and at no other time except reset.
REQ-010 On the edge entering IDLE from SETTLE, o_busy SHALL go to 0 and o_clk_en SHALL take the value of I_enable.
REQ-011 o_clk_en SHALL therefore be low for exactly DRAIN_CYC+1+SETTLE_CYC cycles per ratio change.
REQ-012 In IDLE, o_clk_en SHALL follow I_enable with one cycle of register delay.
REQ-013 Outside IDLE, I_enable SHALL be ignored; its value is sampled only on the edge returning to IDLE.
REQ-014 I_req_vld outside IDLE SHALL be ignored; the requester must hold it until o_req_rdy=1.
REQ-015 The cycle counter SHALL be 8 bits, reload on every state entry and never wrap.

Reset
REQ-016 Asserting I_rst_n=0 SHALL asynchronously force the state to IDLE and the outputs to: o_div_ratio=RESET_RATIO, o_clk_en=0, o_busy=0, o_cfg_err=0, counter=0; o_req_rdy is then 1.
REQ-017 Reset mid-sequence SHALL abort the sequence and discard the captured ratio.
REQ-018 After release, the first o_clk_en=1 SHALL occur no earlier than one edge after I_enable=1 is sampled.

Configuration
REQ-019 Macro CLKDIV_RATIO_CHECK_EN, when defined, SHALL make requests with ratio 0 or 1:
- complete the handshake;
- be discarded, leaving state and outputs unchanged;
- pulse o_cfg_err=1 for exactly one cycle.
REQ-020 With CLKDIV_RATIO_CHECK_EN undefined, every ratio SHALL be sequenced normally and o_cfg_err SHALL be tied to 0.

Verification (DRAIN_CYC=4, SETTLE_CYC=2, RESET_RATIO=2)
REQ-021 Reset, then I_enable=1 -> o_div_ratio=2, o_req_rdy=1, o_clk_en=1 one edge after I_enable is sampled.
REQ-022 Request ratio 5 accepted at edge E0 -> o_clk_en=0 and o_busy=1 from E0; o_div_ratio=5 at E4; o_clk_en=1 and o_busy=0 at E7; o_req_rdy=0 from E0 to E7.
REQ-023 Request ratio 2 while o_div_ratio=2 -> handshake completes, o_clk_en stays 1, o_busy stays 0.
REQ-024 I_enable dropped during SETTLE after a ratio 4 request -> o_div_ratio=4, o_clk_en stays 0 on return to IDLE.
REQ-025 Reset asserted during DRAIN of a ratio 7 request -> o_div_ratio=2, o_clk_en=0, o_busy=0 immediately, with no later change to 7.
REQ-026 With CLKDIV_RATIO_CHECK_EN defined, request ratio 1 -> o_cfg_err pulses for 1 cycle, o_div_ratio is unchanged and o_busy stays 0; with the macro undefined -> o_div_ratio=1 after the full sequence.

Source files
------------

// File: rtl/clkdiv_cfg_ctrl.sv
// ---------------------------------------------------------------------------------------------
// clkdiv_cfg_ctrl
//
// Sequences divide-ratio changes for a clock divider that shares I_ref_clk. A new ratio is
// never applied while the divider runs: the divider enable is dropped for DRAIN_CYC cycles,
// the ratio is loaded in a single cycle, and the enable stays low for SETTLE_CYC more cycles
// before it again follows I_enable.
//
// Optional feature:
//   CLKDIV_RATIO_CHECK_EN  when defined, ratios 0 and 1 are rejected. The handshake still
//                          completes, nothing else changes, and o_cfg_err pulses for one cycle.
//                          When undefined, every ratio is sequenced and o_cfg_err is tied to 0.
//
// Parameters:
//   DRAIN_CYC    cycles the divider is held disabled before the ratio changes (1..255)
//   SETTLE_CYC   cycles the divider is held disabled after the ratio changes (1..255)
//   RESET_RATIO  divide ratio driven out of reset
//
// Ports:
//   I_ref_clk    reference clock, shared with the divider
//   I_rst_n      asynchronous active-low reset
//   I_enable     system request for the divided clock to run (only sampled in IDLE)
//   I_req_vld    new-ratio request valid; must be held until o_req_rdy=1
//   I_req_ratio  requested divide ratio, captured on the accepting edge
//   o_req_rdy    controller can accept a request (IDLE only)
//   o_div_ratio  ratio driven to the divider
//   o_clk_en     enable driven to the divider
//   o_busy       ratio-change sequence in progress
//   o_cfg_err    one-cycle pulse when an illegal ratio is rejected
// ---------------------------------------------------------------------------------------------

module clkdiv_cfg_ctrl #(
    parameter int unsigned DRAIN_CYC   = 4,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter logic [7:0]  RESET_RATIO = 8'd2
) (
    input  logic       I_ref_clk,
    input  logic       I_rst_n,
    input  logic       I_enable,
    input  logic       I_req_vld,
    input  logic [7:0] I_req_ratio,
    output logic       o_req_rdy,
    output logic [7:0] o_div_ratio,
    output logic       o_clk_en,
    output logic       o_busy,
    output logic       o_cfg_err
);

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StLoad,
        StSettle
    } state_e;

    // The counter is loaded with (length - 1) on state entry and the state is left when it
    // reads zero, so a state lasts exactly its configured number of cycles.
    localparam logic [7:0] DrainLoad  = 8'(DRAIN_CYC - 1);
    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYC - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] ratio_q, ratio_d;          // ratio captured on acceptance, applied in LOAD
    logic [7:0] div_ratio_q, div_ratio_d;
    logic       clk_en_q, clk_en_d;
    logic       busy_q, busy_d;
    logic       ratio_ok;                  // request ratio may be sequenced

`ifdef CLKDIV_RATIO_CHECK_EN
    logic       cfg_err_q, cfg_err_d;

    assign ratio_ok = (I_req_ratio > 8'd1);

    // Rejected requests still complete the handshake because o_req_rdy is high in IDLE.
    always_comb begin
        cfg_err_d = 1'b0;
        if ((state_q == StIdle) && I_req_vld && !ratio_ok) begin
            cfg_err_d = 1'b1;
        end
    end

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign o_cfg_err = cfg_err_q;
`else
    assign ratio_ok  = 1'b1;
    assign o_cfg_err = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ratio_d     = ratio_q;
        div_ratio_d = div_ratio_q;
        clk_en_d    = clk_en_q;
        busy_d      = busy_q;

        unique case (state_q)
            StIdle: begin
                clk_en_d = I_enable;
                busy_d   = 1'b0;
                // A request equal to the current ratio is accepted and dropped.
                if (I_req_vld && ratio_ok && (I_req_ratio != div_ratio_q)) begin
                    state_d  = StDrain;
                    cnt_d    = DrainLoad;
                    ratio_d  = I_req_ratio;
                    clk_en_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            StDrain: begin
                if (cnt_q == 8'd0) begin
                    state_d     = StLoad;
                    cnt_d       = 8'd0;
                    div_ratio_d = ratio_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            StLoad: begin
                state_d = StSettle;
                cnt_d   = SettleLoad;
            end

            StSettle: begin
                if (cnt_q == 8'd0) begin
                    state_d  = StIdle;
                    cnt_d    = 8'd0;
                    busy_d   = 1'b0;
                    clk_en_d = I_enable;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            ratio_q     <= RESET_RATIO;
            div_ratio_q <= RESET_RATIO;
            clk_en_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ratio_q     <= ratio_d;
            div_ratio_q <= div_ratio_d;
            clk_en_q    <= clk_en_d;
            busy_q      <= busy_d;
        end
    end

    assign o_req_rdy   = (state_q == StIdle);
    assign o_div_ratio = div_ratio_q;
    assign o_clk_en    = clk_en_q;
    assign o_busy      = busy_q;

endmodule
